// File: rtl/amber128_uart_tx_arb_pkg.sv
// amber128_uart_pkg: shared arbiter state type and limits for the amber128 UART arbiters
package amber128_uart_pkg;
  localparam int ARB_MAX_REQ = 16;
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/amber128_uart_tx_arb_if.sv
// amber128_uart_tx_arb_if: requester byte streams plus the single UART TX byte port
interface amber128_uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0][7:0] req_data_i;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ-1:0]      req_last_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [7:0]              tx_data_o;
  logic                    tx_valid_o;
  logic                    tx_ready_i;
  logic [NUM_REQ-1:0]      grant_o;
  logic                    busy_o;
  logic                    timeout_o;
  modport slave (
    input  req_data_i, req_valid_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_data_o, tx_valid_o, grant_o, busy_o, timeout_o
  );
  modport master (
    output req_data_i, req_valid_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_data_o, tx_valid_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/amber128_uart_tx_arb_rr_pick.sv
// amber128_rr_pick: combinational rotating-priority picker, first set bit at or above the start pointer
module amber128_rr_pick
  import amber128_uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // scan from farthest to nearest so the closest request after the pointer wins
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) o_idx = IW'((int'(i_ptr) + i) % N);
    end
    o_any = |i_req;
  end
endmodule

// File: rtl/amber128_uart_tx_arb.sv
// amber128_uart_tx_arb: round-robin packet-locking arbiter in front of the UART TX; AMBER128_UART_ARB_TIMEOUT_EN adds a stall watchdog
module amber128_uart_tx_arb
  import amber128_uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  amber128_uart_tx_arb_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  arb_state_e    state_q;
  logic [IW-1:0] owner_q, rr_ptr_q, w_pick, w_next;
  logic          w_any, w_busy, w_xfer, w_done, w_to;
  amber128_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req (bus.req_valid_i),
    .i_ptr (rr_ptr_q),
    .o_idx (w_pick),
    .o_any (w_any)
  );
  assign w_busy = state_q == ARB_LOCKED;
  assign w_xfer = w_busy && bus.req_valid_i[owner_q] && bus.tx_ready_i;
  assign w_done = w_xfer && bus.req_last_i[owner_q];
  assign w_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef AMBER128_UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q;
  logic          timeout_q;
  assign w_to = w_busy && !w_xfer && to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
  // count transfer-free locked cycles; idle cycles hold it at zero so lock entry starts fresh
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) to_cnt_q <= '0;
    else to_cnt_q <= (!w_busy || w_xfer || w_to) ? '0 : to_cnt_q + 1'b1;
  end
  // one-cycle pulse in the cycle after the forced release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else timeout_q <= w_to;
  end
  assign bus.timeout_o = timeout_q;
`else
  assign w_to          = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
  // lock on the round-robin pick, release on the owner's last byte or watchdog, advancing the pointer past the owner
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (!w_busy) begin
      if (w_any) begin
        state_q <= ARB_LOCKED;
        owner_q <= w_pick;
      end
    end else if (w_done || w_to) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= w_next;
    end
  end
  // only the owner sees tx ready, so no requester valid can reach any ready combinationally
  always_comb begin
    bus.req_ready_o = '0;
    bus.grant_o     = '0;
    if (w_busy) begin
      bus.req_ready_o[owner_q] = bus.tx_ready_i;
      bus.grant_o[owner_q]     = 1'b1;
    end
  end
  assign bus.tx_valid_o = w_busy && bus.req_valid_i[owner_q];
  assign bus.tx_data_o  = w_busy ? bus.req_data_i[owner_q] : 8'h00;
  assign bus.busy_o     = w_busy;
endmodule

// File: tb/tb_amber128_uart_tx_arb.sv
// tb_amber128_uart_tx_arb: directed self-checking bench for the UART TX arbiter
module tb_amber128_uart_tx_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  amber128_uart_tx_arb_if #(.NUM_REQ(4)) bus ();
  amber128_uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic clear_inputs;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.req_data_i  = '0;
    bus.tx_ready_i  = 1'b1;
  endtask
  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    #3;
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    clear_inputs();
    bus.req_valid_i = 4'hF;
    #1 rst_n = 1'b0;
    #2;
    n_chk++; if ({bus.busy_o, bus.tx_valid_o, bus.timeout_o} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {bus.busy_o, bus.tx_valid_o, bus.timeout_o}); else n_pass++;
    n_chk++; if (bus.grant_o !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", bus.grant_o); else n_pass++;
    n_chk++; if (bus.req_ready_o !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", bus.req_ready_o); else n_pass++;
    n_chk++; if (bus.tx_data_o !== 8'h00) $display("FAIL rst_data: got %h want 00", bus.tx_data_o); else n_pass++;
    step();
    step();
    n_chk++; if (bus.busy_o !== 1'b0) $display("FAIL rst_hold: got %b want 0", bus.busy_o); else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_single;
    bus.req_valid_i[2] = 1'b1;
    bus.req_data_i[2]  = 8'h48;
    #1;
    n_chk++; if ({bus.busy_o, bus.req_ready_o} !== 5'b0) $display("FAIL single_bubble: got %b want 00000", {bus.busy_o, bus.req_ready_o}); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.grant_o); else n_pass++;
    n_chk++; if (bus.tx_data_o !== 8'h48 || bus.tx_valid_o !== 1'b1) $display("FAIL single_byte0: got %h/%b want 48/1", bus.tx_data_o, bus.tx_valid_o); else n_pass++;
    n_chk++; if (bus.req_ready_o !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus.req_ready_o); else n_pass++;
    step();
    bus.req_data_i[2] = 8'h69;
    bus.req_last_i[2] = 1'b1;
    #1;
    n_chk++; if (bus.tx_data_o !== 8'h69 || bus.busy_o !== 1'b1) $display("FAIL single_byte1: got %h/%b want 69/1", bus.tx_data_o, bus.busy_o); else n_pass++;
    step();
    clear_inputs();
    #1;
    n_chk++; if ({bus.busy_o, bus.grant_o} !== 5'b0) $display("FAIL single_release: got %b want 00000", {bus.busy_o, bus.grant_o}); else n_pass++;
    bus.req_valid_i = 4'b1001;
    bus.req_last_i  = 4'b1001;
    bus.req_data_i[0] = 8'h30;
    bus.req_data_i[3] = 8'h33;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b1000) $display("FAIL single_rrptr: got %b want 1000", bus.grant_o); else n_pass++;
    step();
    bus.req_valid_i[3] = 1'b0;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0001) $display("FAIL single_wrap: got %b want 0001", bus.grant_o); else n_pass++;
    step();
    clear_inputs();
    step();
  endtask
  task automatic test_fairness;
    do_reset();
    bus.req_valid_i = 4'hF;
    bus.req_last_i  = 4'hF;
    for (int i = 0; i < 4; i++) bus.req_data_i[i] = 8'(8'hA0 + i);
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      step();
      #1;
      n_chk++; if (bus.grant_o !== 4'(1 << e) || bus.tx_data_o !== 8'(8'hA0 + e)) $display("FAIL fair_grant%0d: got %b/%h want %b/%h", k, bus.grant_o, bus.tx_data_o, 4'(1 << e), 8'(8'hA0 + e)); else n_pass++;
      step();
      #1;
      n_chk++; if (bus.busy_o !== 1'b0) $display("FAIL fair_bubble%0d: got %b want 0", k, bus.busy_o); else n_pass++;
    end
    clear_inputs();
    step();
  endtask
  task automatic test_no_interleave;
    logic [5:0] tv;
    logic [5:0] tl;
    tv = 6'b100101;
    tl = 6'b100000;
    do_reset();
    bus.req_valid_i[1] = 1'b1;
    bus.req_last_i[1]  = 1'b1;
    bus.req_data_i[1]  = 8'h11;
    bus.req_valid_i[0] = tv[0];
    bus.req_last_i[0]  = tl[0];
    bus.req_data_i[0]  = 8'hB0;
    step();
    for (int k = 0; k < 6; k++) begin
      bus.req_valid_i[0] = tv[k];
      bus.req_last_i[0]  = tl[k];
      bus.req_data_i[0]  = 8'(8'hB0 + k);
      #1;
      n_chk++; if (bus.req_ready_o !== 4'b0001 || bus.tx_valid_o !== tv[k]) $display("FAIL noint_cycle%0d: got %b/%b want 0001/%b", k, bus.req_ready_o, bus.tx_valid_o, tv[k]); else n_pass++;
      step();
    end
    bus.req_valid_i[0] = 1'b0;
    bus.req_last_i[0]  = 1'b0;
    #1;
    n_chk++; if ({bus.busy_o, bus.req_ready_o} !== 5'b0) $display("FAIL noint_release: got %b want 00000", {bus.busy_o, bus.req_ready_o}); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0010 || bus.tx_data_o !== 8'h11) $display("FAIL noint_next: got %b/%h want 0010/11", bus.grant_o, bus.tx_data_o); else n_pass++;
    step();
    clear_inputs();
    step();
  endtask
  task automatic test_backpressure;
    int bad;
    bad = 0;
    do_reset();
    bus.req_valid_i[3] = 1'b1;
    bus.req_data_i[3]  = 8'hC1;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b1000 || bus.tx_data_o !== 8'hC1) $display("FAIL bp_first: got %b/%h want 1000/c1", bus.grant_o, bus.tx_data_o); else n_pass++;
    step();
    bus.req_data_i[3]  = 8'hC2;
    bus.req_last_i[3]  = 1'b1;
    bus.tx_ready_i     = 1'b0;
    bus.req_valid_i[0] = 1'b1;
    bus.req_last_i[0]  = 1'b1;
    bus.req_data_i[0]  = 8'h5A;
    repeat (50) begin
      #1;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'hC2 || bus.grant_o !== 4'b1000 || bus.req_ready_o !== 4'b0000) bad++;
      step();
    end
    n_chk++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad); else n_pass++;
    bus.tx_ready_i = 1'b1;
    #1;
    n_chk++; if (bus.req_ready_o !== 4'b1000 || bus.tx_data_o !== 8'hC2) $display("FAIL bp_resume: got %b/%h want 1000/c2", bus.req_ready_o, bus.tx_data_o); else n_pass++;
    step();
    bus.req_valid_i[3] = 1'b0;
    bus.req_last_i[3]  = 1'b0;
    #1;
    n_chk++; if (bus.busy_o !== 1'b0) $display("FAIL bp_release: got %b want 0", bus.busy_o); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0001 || bus.tx_data_o !== 8'h5A) $display("FAIL bp_next: got %b/%h want 0001/5a", bus.grant_o, bus.tx_data_o); else n_pass++;
    step();
    clear_inputs();
    step();
  endtask
  task automatic test_timeout;
    int bad;
    bad = 0;
    do_reset();
    bus.req_valid_i[1] = 1'b1;
    bus.req_data_i[1]  = 8'h77;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0010) $display("FAIL to_grant: got %b want 0010", bus.grant_o); else n_pass++;
    step();
    bus.req_valid_i[1] = 1'b0;
`ifdef AMBER128_UART_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      #1;
      if (bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL to_early: got %0d bad cycles want 0", bad); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b1) $display("FAIL to_fire: got busy %b pulse %b want 0/1", bus.busy_o, bus.timeout_o); else n_pass++;
    bus.req_valid_i = 4'b0101;
    bus.req_last_i  = 4'b0101;
    step();
    #1;
    n_chk++; if (bus.timeout_o !== 1'b0 || bus.grant_o !== 4'b0100) $display("FAIL to_next: got pulse %b grant %b want 0/0100", bus.timeout_o, bus.grant_o); else n_pass++;
`else
    repeat (100) begin
      step();
      #1;
      if (bus.busy_o !== 1'b1 || bus.grant_o !== 4'b0010 || bus.timeout_o !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL to_hold: got %0d bad cycles want 0", bad); else n_pass++;
`endif
    do_reset();
  endtask
  task automatic test_reset_mid;
    do_reset();
    bus.req_valid_i = 4'b1100;
    bus.req_data_i[2] = 8'h22;
    bus.req_data_i[3] = 8'h33;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0100) $display("FAIL rmid_grant: got %b want 0100", bus.grant_o); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.busy_o, bus.tx_valid_o, bus.timeout_o, bus.grant_o, bus.req_ready_o} !== 11'b0) $display("FAIL rmid_async: got %b want 0", {bus.busy_o, bus.tx_valid_o, bus.timeout_o, bus.grant_o, bus.req_ready_o}); else n_pass++;
    n_chk++; if (bus.tx_data_o !== 8'h00) $display("FAIL rmid_data: got %h want 00", bus.tx_data_o); else n_pass++;
    bus.req_valid_i = 4'b1010;
    bus.req_last_i  = 4'b1010;
    step();
    step();
    rst_n = 1'b1;
    step();
    #1;
    n_chk++; if (bus.grant_o !== 4'b0010) $display("FAIL rmid_first: got %b want 0010", bus.grant_o); else n_pass++;
    clear_inputs();
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
